// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding
// and frame geometry (header, payload word and trailer sizes in bytes).
package instruction_memory_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HEADER_BYTES   = 4;
  localparam int TRAILER_BYTES  = 4;

endpackage

// File: rtl/instruction_memory_loader_assembler.sv
// Little-endian byte-to-word assembler: byte k of each group of four lands in
// bits [8k+7:8k]; word_complete pulses in the same cycle the fourth byte is accepted.
module byte_word_assembler
  import instruction_memory_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  count;
  logic [23:0] shift;

  // The top byte comes straight from the input so the full word is usable on
  // the accepting edge, which keeps the RAM write one cycle behind the last byte.
  assign word_complete = strobe && (count == 2'(BYTES_PER_WORD - 1));
  assign word          = {byte_in, shift};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 2'd0;
      shift <= 24'd0;
    end else if (strobe) begin
      count <= count + 2'd1;
      shift <= {byte_in, shift[23:8]};
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Boot loader write side: parses LEN | payload words | CSUM frames from a byte
// stream, writes each word sequentially into instruction RAM and verifies the XOR trailer.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDRESS = 64'h0,
  parameter int          DEPTH_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWriteEnable,
  output logic [63:0] memWriteAddress,
  output logic [31:0] memWriteData,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t      state;
  logic [31:0] length;
  logic [31:0] word_count;
  logic [31:0] checksum;
  logic [31:0] word;
  logic        word_complete;
  logic        accept;
  logic        clear;

  assign accept = byteValid && byteReady;
  // busy is low exactly in IDLE/DONE/ERROR, so this is the only accepted start
  assign clear  = start && !busy;

  byte_word_assembler u_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .strobe       (accept),
    .byte_in      (byteIn),
    .word         (word),
    .word_complete(word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      byteReady       <= 1'b0;
      memWriteEnable  <= 1'b0;
      memWriteAddress <= BASE_ADDRESS;
      memWriteData    <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      length          <= 32'd0;
      word_count      <= 32'd0;
      checksum        <= 32'd0;
    end else begin
      memWriteEnable <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LEN;
            byteReady  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            length     <= 32'd0;
            word_count <= 32'd0;
            checksum   <= 32'd0;
          end
        end
        ST_LEN: begin
          if (word_complete) begin
            length <= word;
            if (word > 32'(DEPTH_WORDS)) begin
              state     <= ST_ERROR;
              error     <= 1'b1;
              busy      <= 1'b0;
              byteReady <= 1'b0;
            end else if (word == 32'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_complete) begin
            memWriteEnable  <= 1'b1;
            memWriteData    <= word;
            memWriteAddress <= BASE_ADDRESS + 64'({word_count, 2'b00});
            checksum        <= checksum ^ word;
            word_count      <= word_count + 32'd1;
            if (word_count == length - 32'd1) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (word_complete) begin
            busy      <= 1'b0;
            byteReady <= 1'b0;
            if (word == checksum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          byteReady <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: stimulus pushes expected RAM
// writes into a queue, a negedge monitor pops and compares every write strobe.
module tb_instruction_memory_loader;

  localparam logic [63:0] BASE = 64'h0;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } write_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'd0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        memWriteEnable;
  logic [63:0] memWriteAddress;
  logic [31:0] memWriteData;
  logic        busy;
  logic        done;
  logic        error;

  int          checks = 0;
  int          failures = 0;
  write_t      exp_q[$];
  logic [31:0] frame_words[$];

  instruction_memory_loader #(.BASE_ADDRESS(BASE), .DEPTH_WORDS(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .byteIn         (byteIn),
    .byteValid      (byteValid),
    .byteReady      (byteReady),
    .memWriteEnable (memWriteEnable),
    .memWriteAddress(memWriteAddress),
    .memWriteData   (memWriteData),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (memWriteEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write addr=%0h data=%0h expected=none",
                 memWriteAddress, memWriteData);
      end else begin
        write_t e;
        e = exp_q.pop_front();
        check_output("write_addr", memWriteAddress, e.addr);
        check_output("write_data", 64'(memWriteData), 64'(e.data));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int wait_cycles;
    if (gaps) begin
      for (int g = 0; g < 6 && $urandom_range(1, 0) == 0; g++) begin
        byteValid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    byteIn = b;
    byteValid = 1'b1;
    wait_cycles = 0;
    while (byteReady !== 1'b1 && wait_cycles < 20) begin
      @(posedge clk);
      #1;
      wait_cycles++;
    end
    if (byteReady !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL byte_timeout actual=not_ready expected=ready");
    end else begin
      @(posedge clk);
      #1;
    end
    byteValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  // Sends a full frame built from frame_words, queueing the expected RAM writes
  task automatic apply_stimulus(input logic [31:0] csum, input bit gaps);
    pulse_start();
    send_word(32'(frame_words.size()), gaps);
    for (int i = 0; i < frame_words.size(); i++) begin
      exp_q.push_back('{addr: BASE + 64'(4 * i), data: frame_words[i]});
      send_word(frame_words[i], gaps);
    end
    send_word(csum, gaps);
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_error);
    check_output({tag, "_done"}, 64'(done), 64'(exp_done));
    check_output({tag, "_error"}, 64'(error), 64'(exp_error));
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_ready"}, 64'(byteReady), 64'd0);
  endtask

  task automatic check_drained(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_output({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check_output({tag, "_ready"}, 64'(byteReady), 64'd0);
    check_output({tag, "_we"}, 64'(memWriteEnable), 64'd0);
    check_output({tag, "_addr"}, memWriteAddress, BASE);
    check_output({tag, "_data"}, 64'(memWriteData), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_output({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Case 1: two words, correct checksum
    frame_words = '{32'h00000013, 32'h00100093};
    apply_stimulus(32'h00100080, 1'b0);
    check_status("c1", 1'b1, 1'b0);
    check_drained("c1");
    check_output("c1_addr_hold", memWriteAddress, BASE + 64'h4);

    // Case 2: same payload, bad checksum; writes still happen
    apply_stimulus(32'hDEADBEEF, 1'b0);
    check_status("c2", 1'b0, 1'b1);
    check_drained("c2");

    // Case 3: oversize length rejected after the header, later bytes refused
    pulse_start();
    check_output("c3_busy_during", 64'(busy), 64'd1);
    send_word(32'd1025, 1'b0);
    check_status("c3", 1'b0, 1'b1);
    byteValid = 1'b1;
    byteIn = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("c3_refuse", 64'(byteReady), 64'd0);
    end
    byteValid = 1'b0;
    check_drained("c3");

    // Case 4: empty image, good and bad trailer
    frame_words = {};
    apply_stimulus(32'h0, 1'b0);
    check_status("c4a", 1'b1, 1'b0);
    apply_stimulus(32'h1, 1'b0);
    check_status("c4b", 1'b0, 1'b1);
    check_drained("c4");

    // Case 5: case 1 with random gaps in byteValid
    frame_words = '{32'h00000013, 32'h00100093};
    apply_stimulus(32'h00100080, 1'b1);
    check_status("c5", 1'b1, 1'b0);
    check_drained("c5");

    // Case 6: ignored mid-load start, then reset after the first word
    pulse_start();
    send_word(32'd2, 1'b0);
    pulse_start();
    check_output("c6_busy_after_start", 64'(busy), 64'd1);
    exp_q.push_back('{addr: BASE, data: 32'h00000013});
    send_word(32'h00000013, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    check_reset_values("c6_reset");
    reset = 1'b0;
    check_drained("c6_pre");
    apply_stimulus(32'h00100080, 1'b0);
    check_status("c6", 1'b1, 1'b0);
    check_drained("c6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
